// File: rtl/dmadd_sequencer_if.sv
// rtl/dmadd_sequencer_if.sv - host job/beat handshake, status and datapath control bundle for dmadd_sequencer
interface dmadd_sequencer_if;
    logic        start;
    logic [1:0]  mode;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_index;
    logic [3:0]  in_data;
    logic        in_last;

    logic        dp_rst_n;
    logic [1:0]  dp_insn;
    logic        dp_load;
    logic        dp_run;
    logic [3:0]  dp_index;
    logic [3:0]  dp_data;
    logic [7:0]  dp_out;
    logic [3:0]  dp_out_top;

    logic        busy;
    logic        done;
    logic        err;
    logic        overflow;
    logic [11:0] result;

    // master: host plus datapath result side; slave: the sequencer itself
    modport master (
        output start, mode, abort, in_valid, in_index, in_data, in_last,
        output dp_out, dp_out_top,
        input  in_ready, dp_rst_n, dp_insn, dp_load, dp_run, dp_index, dp_data,
        input  busy, done, err, overflow, result
    );

    modport slave (
        input  start, mode, abort, in_valid, in_index, in_data, in_last,
        input  dp_out, dp_out_top,
        output in_ready, dp_rst_n, dp_insn, dp_load, dp_run, dp_index, dp_data,
        output busy, done, err, overflow, result
    );
endinterface

// File: rtl/dmadd_sequencer.sv
// rtl/dmadd_sequencer.sv - job sequencer driving clear/init/load/run/settle phases of one DMADD datapath
module dmadd_sequencer #(
    parameter int RUN_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_BEATS     = 16
) (
    input logic              clk,
    input logic              rst_n,
    dmadd_sequencer_if.slave bus
);

    localparam logic [7:0] RUN_LAST    = 8'(RUN_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [4:0] BEAT_LIMIT  = 5'(MAX_BEATS);
    localparam logic [1:0] MODE_MAX    = 2'b01;
    localparam logic [1:0] MODE_MADD   = 2'b10;
    localparam logic [1:0] MODE_BAD    = 2'b11;

    // S_LEND is the final dp_load cycle: loading has ended but run starts one cycle later
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_LEND,
        S_RUN,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [4:0]  beat_q, beat_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        dp_rst_n_q, dp_rst_n_d;
    logic [1:0]  dp_insn_q, dp_insn_d;
    logic        dp_load_q, dp_load_d;
    logic        dp_run_q, dp_run_d;
    logic [3:0]  dp_index_q, dp_index_d;
    logic [3:0]  dp_data_q, dp_data_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;
    logic [11:0] result_q, result_d;

    logic        accept;
    logic [4:0]  beat_inc;
    logic [1:0]  ie_d;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        dp_index_d = dp_index_q;
        dp_data_d  = dp_data_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        dp_load_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        accept     = bus.in_valid & in_ready_q;
        beat_inc   = (beat_q == 5'h1f) ? beat_q : beat_q + 5'd1;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.mode == MODE_BAD) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = bus.mode;
                        beat_d  = 5'd0;
                        ovf_d   = 1'b0;
                        state_d = S_INIT;
                    end
                end
            end
            S_INIT: state_d = S_LOAD;
            S_LOAD: begin
                if (accept) begin
                    dp_load_d  = 1'b1;
                    dp_index_d = bus.in_index;
                    dp_data_d  = bus.in_data;
                    beat_d     = beat_inc;
                    if (bus.in_last || beat_inc >= BEAT_LIMIT) begin
                        ovf_d   = ~bus.in_last;
                        state_d = S_LEND;
                    end
                end
            end
            S_LEND: begin
                cnt_d   = 8'd0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    result_d = {bus.dp_out_top, bus.dp_out};
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // abort overrides every transition, including a start seen in IDLE
        if (bus.abort) begin
            state_d   = S_IDLE;
            mode_d    = mode_q;
            beat_d    = beat_q;
            cnt_d     = 8'd0;
            ovf_d     = ovf_q;
            result_d  = result_q;
            dp_load_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b0;
        end

        // MADD initialises with the MAX encoding
        ie_d       = (mode_d == MODE_MADD) ? MODE_MAX : mode_d;
        dp_rst_n_d = (state_d != S_IDLE);
        dp_run_d   = (state_d == S_RUN);
        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE);
        if (state_d == S_IDLE) begin
            dp_insn_d = 2'b00;
        end else if (dp_load_d || dp_run_d) begin
            dp_insn_d = mode_d;
        end else begin
            dp_insn_d = ie_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'b00;
            beat_q     <= 5'd0;
            cnt_q      <= 8'd0;
            dp_rst_n_q <= 1'b0;
            dp_insn_q  <= 2'b00;
            dp_load_q  <= 1'b0;
            dp_run_q   <= 1'b0;
            dp_index_q <= 4'd0;
            dp_data_q  <= 4'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            result_q   <= 12'd0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            dp_rst_n_q <= dp_rst_n_d;
            dp_insn_q  <= dp_insn_d;
            dp_load_q  <= dp_load_d;
            dp_run_q   <= dp_run_d;
            dp_index_q <= dp_index_d;
            dp_data_q  <= dp_data_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
        end
    end

    assign bus.dp_rst_n = dp_rst_n_q;
    assign bus.dp_insn  = dp_insn_q;
    assign bus.dp_load  = dp_load_q;
    assign bus.dp_run   = dp_run_q;
    assign bus.dp_index = dp_index_q;
    assign bus.dp_data  = dp_data_q;
    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.overflow = ovf_q;
    assign bus.result   = result_q;

endmodule

// File: tb/tb_dmadd_sequencer.sv
// tb/tb_dmadd_sequencer.sv - directed self-checking bench for dmadd_sequencer with a behavioural datapath
module tb_dmadd_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmadd_sequencer_if bus();

    dmadd_sequencer #(
        .RUN_CYCLES   (16),
        .SETTLE_CYCLES(2),
        .MAX_BEATS    (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // datapath stand-in: first load seeds, later loads fold by MIN / MAX / multiply-accumulate
    logic [11:0] acc   = 12'd0;
    logic        first = 1'b1;
    logic [11:0] beat_val;
    assign beat_val = (bus.dp_insn == 2'b10) ? ({8'h00, bus.dp_index} * {8'h00, bus.dp_data})
                                             : {8'h00, bus.dp_index};
    always @(posedge clk) begin
        if (bus.dp_rst_n !== 1'b1) begin
            first <= 1'b1;
        end else if (bus.dp_load === 1'b1) begin
            first <= 1'b0;
            if (first) acc <= beat_val;
            else if (bus.dp_insn == 2'b00) acc <= (beat_val < acc) ? beat_val : acc;
            else if (bus.dp_insn == 2'b01) acc <= (beat_val > acc) ? beat_val : acc;
            else acc <= acc + beat_val;
        end
    end
    assign bus.dp_out     = acc[7:0];
    assign bus.dp_out_top = acc[11:8];

    int cyc = 0, load_cnt = 0, run_cnt = 0, done_cnt = 0, last_load_cyc = 0, done_cyc = 0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.dp_load === 1'b1) begin load_cnt = load_cnt + 1; last_load_cyc = cyc; end
        if (bus.dp_run === 1'b1) run_cnt = run_cnt + 1;
        if (bus.done === 1'b1) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    end

    logic [3:0] madd_idx [3] = '{4'd2, 4'd4, 4'd1};
    logic [3:0] madd_dat [3] = '{4'd3, 4'd5, 4'd7};

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [1:0] m);
        bus.mode  = m;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] i, input logic [3:0] d, input logic l);
        logic got;
        got          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_index = i;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int k = 0; k < 40 && !got; k++) begin
            got = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL beat_timeout: in_ready got 0 for 40 cycles, expected 1");
        end
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step();
            seen = bus.done;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: done got 0 for 100 cycles, expected 1");
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++;
        if ({bus.dp_rst_n, bus.dp_load, bus.dp_run, bus.dp_insn, bus.dp_index, bus.dp_data,
             bus.in_ready, bus.busy, bus.done, bus.err, bus.overflow} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0", {bus.dp_rst_n, bus.dp_load, bus.dp_run,
                     bus.dp_insn, bus.dp_index, bus.dp_data, bus.in_ready, bus.busy, bus.done, bus.err, bus.overflow});
        end
        n_cmp++;
        if (bus.result !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 000", bus.result);
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        step();
        step();
        n_cmp++;
        if ({bus.in_ready, bus.busy, bus.dp_load} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_ignores_valid: got %b expected 000", {bus.in_ready, bus.busy, bus.dp_load});
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_min();
        int l0, r0, d0;
        l0 = load_cnt; r0 = run_cnt; d0 = done_cnt;
        do_start(2'b00);
        send_beat(4'd5, 4'd0, 1'b0);
        send_beat(4'd9, 4'd0, 1'b1);
        wait_done();
        n_cmp++;
        if (load_cnt - l0 != 2 || run_cnt - r0 != 16 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL min_counts: got load=%0d run=%0d done=%0d expected 2/16/1",
                     load_cnt - l0, run_cnt - r0, done_cnt - d0);
        end
        n_cmp++;
        if (bus.result !== 12'h005 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL min_result: got result=%h busy=%b expected 005/0", bus.result, bus.busy);
        end
    endtask

    task automatic test_max();
        do_start(2'b01);
        send_beat(4'd3, 4'd0, 1'b0);
        send_beat(4'd12, 4'd0, 1'b1);
        wait_done();
        n_cmp++;
        if (bus.result !== 12'h00C || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL max_result: got result=%h overflow=%b expected 00c/0", bus.result, bus.overflow);
        end
    endtask

    task automatic test_madd_back_to_back();
        int l0, r0;
        l0 = load_cnt; r0 = run_cnt;
        do_start(2'b10);
        n_cmp++;
        if ({bus.dp_insn, bus.dp_rst_n, bus.busy, bus.dp_load} !== 5'b01110) begin
            n_fail++;
            $display("FAIL madd_init: got insn/rst/busy/load=%b expected 01110",
                     {bus.dp_insn, bus.dp_rst_n, bus.busy, bus.dp_load});
        end
        step();
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL madd_ready: got %b expected 1", bus.in_ready);
        end
        for (int b = 0; b < 3; b++) begin
            bus.in_valid = 1'b1;
            bus.in_index = madd_idx[b];
            bus.in_data  = madd_dat[b];
            bus.in_last  = (b == 2);
            step();
            n_cmp++;
            if ({bus.dp_load, bus.dp_insn, bus.dp_index, bus.dp_data} !== {1'b1, 2'b10, madd_idx[b], madd_dat[b]}) begin
                n_fail++;
                $display("FAIL madd_load%0d: got %b expected %b", b,
                         {bus.dp_load, bus.dp_insn, bus.dp_index, bus.dp_data},
                         {1'b1, 2'b10, madd_idx[b], madd_dat[b]});
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL madd_ready_after_last: got %b expected 0", bus.in_ready);
        end
        wait_done();
        n_cmp++;
        if (load_cnt - l0 != 3 || run_cnt - r0 != 16 || done_cyc - last_load_cyc != 19) begin
            n_fail++;
            $display("FAIL madd_timing: got load=%0d run=%0d done_gap=%0d expected 3/16/19",
                     load_cnt - l0, run_cnt - r0, done_cyc - last_load_cyc);
        end
        n_cmp++;
        if (bus.result !== 12'h021) begin
            n_fail++;
            $display("FAIL madd_result: got %h expected 021", bus.result);
        end
    endtask

    task automatic test_overflow();
        int l0, accepted;
        logic got;
        l0 = load_cnt;
        accepted = 0;
        do_start(2'b01);
        for (int k = 0; k < 25; k++) begin
            bus.in_valid = 1'b1;
            bus.in_index = 4'(accepted);
            bus.in_data  = 4'd1;
            bus.in_last  = 1'b0;
            got = bus.in_ready;
            step();
            if (got) accepted++;
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (accepted != 16 || load_cnt - l0 != 16 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_beats: got accepted=%0d loads=%0d ready=%b expected 16/16/0",
                     accepted, load_cnt - l0, bus.in_ready);
        end
        wait_done();
        n_cmp++;
        if (bus.overflow !== 1'b1 || bus.result !== 12'h00F) begin
            n_fail++;
            $display("FAIL ovf_flag: got overflow=%b result=%h expected 1/00f", bus.overflow, bus.result);
        end
    endtask

    task automatic test_abort();
        int d0;
        do_start(2'b00);
        send_beat(4'd7, 4'd0, 1'b1);
        for (int k = 0; k < 5; k++) step();
        n_cmp++;
        if (bus.dp_run !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_in_run: got dp_run=%b expected 1", bus.dp_run);
        end
        d0 = done_cnt;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        n_cmp++;
        if ({bus.dp_run, bus.dp_rst_n, bus.busy, bus.done, bus.in_ready} !== 5'b00000) begin
            n_fail++;
            $display("FAIL abort_outputs: got run/rst/busy/done/ready=%b expected 00000",
                     {bus.dp_run, bus.dp_rst_n, bus.busy, bus.done, bus.in_ready});
        end
        for (int k = 0; k < 30; k++) step();
        n_cmp++;
        if (done_cnt != d0 || bus.result !== 12'h00F || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_after: got done_pulses=%0d result=%h overflow=%b expected 0/00f/0",
                     done_cnt - d0, bus.result, bus.overflow);
        end
    endtask

    task automatic test_err_and_start_abort();
        do_start(2'b11);
        n_cmp++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse: got err=%b busy=%b expected 1/0", bus.err, bus.busy);
        end
        step();
        n_cmp++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_one_cycle: got err=%b busy=%b expected 0/0", bus.err, bus.busy);
        end
        bus.abort = 1'b1;
        do_start(2'b00);
        bus.abort = 1'b0;
        step();
        n_cmp++;
        if ({bus.busy, bus.dp_rst_n, bus.in_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL start_abort: got busy/rst/ready=%b expected 000", {bus.busy, bus.dp_rst_n, bus.in_ready});
        end
    endtask

    task automatic test_async_reset();
        int d0;
        do_start(2'b01);
        step();
        bus.in_valid = 1'b1;
        bus.in_index = 4'd9;
        bus.in_data  = 4'd0;
        bus.in_last  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.dp_rst_n, bus.in_ready, bus.busy, bus.dp_insn, bus.dp_load, bus.overflow} !== 7'd0
            || bus.result !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: got rst/ready/busy/insn/load/ovf=%b result=%h expected 0/000",
                     {bus.dp_rst_n, bus.in_ready, bus.busy, bus.dp_insn, bus.dp_load, bus.overflow}, bus.result);
        end
        step();
        n_cmp++;
        if (bus.dp_load !== 1'b0 || bus.dp_index !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset_beat: got load=%b index=%h expected 0/0", bus.dp_load, bus.dp_index);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst_n = 1'b1;
        step();
        d0 = done_cnt;
        do_start(2'b00);
        send_beat(4'd4, 4'd0, 1'b0);
        send_beat(4'd6, 4'd0, 1'b1);
        wait_done();
        n_cmp++;
        if (bus.result !== 12'h004 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL post_reset_job: got result=%h done_pulses=%0d expected 004/1", bus.result, done_cnt - d0);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.mode     = 2'b00;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_index = 4'd0;
        bus.in_data  = 4'd0;
        bus.in_last  = 1'b0;
        test_reset();
        test_min();
        test_max();
        test_madd_back_to_back();
        test_overflow();
        test_abort();
        test_err_and_start_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
